// File: rtl/clk_rst_seq_pkg.sv
// Shared types and helpers for the clock/reset sequencer.
package clk_rst_seq_pkg;

  typedef enum logic [1:0] {
    StHold,
    StStretch,
    StRelease,
    StRun
  } seq_state_t;

  // 27-bit "status" blink pattern, zero-extended to 32 bits.
  localparam logic [31:0] DEFAULT_BLINK_PATTERN = 32'h0151DDC5;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level input.
module sync_chain #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk_rst_seq.sv
// Clock/reset generator: synchronises PLL lock, stretches reset, releases
// staged domain resets and produces a programmable divided clock.
// Optional blink-pattern status LED: define CLK_RST_SEQ_BLINK_EN.
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 15
`ifdef CLK_RST_SEQ_BLINK_EN
  ,
  parameter logic [31:0] BLINK_PATTERN = DEFAULT_BLINK_PATTERN,
  parameter int unsigned BLINK_SHIFT   = 21
`endif
) (
  input  logic                   CLK_16mhz,
  input  logic                   resetn,
  input  logic                   pll_locked,
  input  logic [DIV_W-1:0]       div_value,
  input  logic                   div_load,
  output logic                   clk_out,
  output logic                   clk_en,
  output logic [NUM_DOMAINS-1:0] domain_resetn,
  output logic                   seq_done,
  output logic                   led
);

  localparam int unsigned RST_W = cnt_width(RST_CYCLES);
  localparam int unsigned GAP_W = cnt_width(STAGE_GAP);
  localparam int unsigned CNT_W = (RST_W > GAP_W) ? RST_W : GAP_W;
  localparam int unsigned IDX_W = cnt_width(NUM_DOMAINS);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

  logic lock_s;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (CLK_16mhz),
    .rst_n (resetn),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // ---------------------------------------------------------------------------
  // Reset sequencer
  // ---------------------------------------------------------------------------
  seq_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   done_q, done_d;
  logic                   rel_en;
  logic [IDX_W-1:0]       rel_idx;

  // Next-state logic: lock loss overrides everything and restarts from hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    rel_en  = 1'b0;
    rel_idx = idx_q;
    if (!lock_s) begin
      state_d = StHold;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          state_d = StStretch;
          cnt_d   = '0;
        end
        StStretch: begin
          if (cnt_q == RST_LAST) begin
            // Domain 0 is released on the edge that enters the release phase.
            rel_en  = 1'b1;
            rel_idx = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRelease: begin
          if (cnt_q == GAP_LAST) begin
            rel_en = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          done_d = 1'b1;
        end
        default: state_d = StHold;
      endcase
      if (rel_en) begin
        dom_d = dom_q | (NUM_DOMAINS'(1) << rel_idx);
        cnt_d = '0;
        if (rel_idx == IDX_LAST) begin
          state_d = StRun;
          done_d  = 1'b1;
        end else begin
          state_d = StRelease;
          idx_d   = rel_idx + 1'b1;
        end
      end
    end
  end

  // Sequencer state and registered reset outputs.
  always_ff @(posedge CLK_16mhz or negedge resetn) begin
    if (!resetn) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Clock divider with deferred divisor load
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_reg_q, div_reg_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_en_q, clk_en_d;
  logic             div_hit;

  // Count half periods; a new divisor only takes effect on a falling toggle so
  // the high phase in progress keeps its length.
  always_comb begin
    div_hit    = (div_cnt_q == div_reg_q);
    div_cnt_d  = div_hit ? '0 : div_cnt_q + 1'b1;
    clk_out_d  = clk_out_q ^ div_hit;
    clk_en_d   = div_hit & ~clk_out_q;
    div_reg_d  = div_reg_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (div_hit && clk_out_q && pend_vld_q) begin
      div_reg_d  = pend_q;
      pend_vld_d = 1'b0;
    end
    // Captured after the apply check, so a load on a falling toggle waits.
    if (div_load) begin
      pend_d     = div_value;
      pend_vld_d = 1'b1;
    end
  end

  // Divider state.
  always_ff @(posedge CLK_16mhz or negedge resetn) begin
    if (!resetn) begin
      div_cnt_q  <= '0;
      div_reg_q  <= DIV_W'(DIV_DEFAULT);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      clk_en_q   <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      div_reg_q  <= div_reg_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      clk_en_q   <= clk_en_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Status LED
  // ---------------------------------------------------------------------------
  logic led_q, led_d;

`ifdef CLK_RST_SEQ_BLINK_EN
  logic [BLINK_SHIFT+4:0] blink_q, blink_d;

  // Free-running pattern step counter; pattern shown only once sequenced.
  always_comb begin
    blink_d = blink_q + 1'b1;
    led_d   = done_d ? BLINK_PATTERN[blink_d[BLINK_SHIFT+4:BLINK_SHIFT]] : 1'b0;
  end

  // Blink counter.
  always_ff @(posedge CLK_16mhz or negedge resetn) begin
    if (!resetn) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  // Flash at the divided clock rate once sequenced.
  always_comb begin
    led_d = clk_out_d & done_d;
  end
`endif

  // Registered LED output.
  always_ff @(posedge CLK_16mhz or negedge resetn) begin
    if (!resetn) begin
      led_q <= 1'b0;
    end else begin
      led_q <= led_d;
    end
  end

  assign clk_out       = clk_out_q;
  assign clk_en        = clk_en_q;
  assign domain_resetn = dom_q;
  assign seq_done      = done_q;
  assign led           = led_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Self-checking bench for clk_rst_seq (default parameters).
module tb_clk_rst_seq;

  localparam int N      = 3;
  localparam int S      = 3;
  localparam int R      = 16;
  localparam int G      = 4;
  localparam int DIVD   = 15;
  localparam int BSHIFT = 21;
  localparam logic [31:0] PATTERN = 32'h0151DDC5;

  logic       CLK_16mhz = 1'b0;
  logic       resetn    = 1'b1;
  logic       pll_locked = 1'b0;
  logic [7:0] div_value = 8'd0;
  logic       div_load  = 1'b0;
  logic       clk_out;
  logic       clk_en;
  logic [N-1:0] domain_resetn;
  logic       seq_done;
  logic       led;

  clk_rst_seq dut (
    .CLK_16mhz     (CLK_16mhz),
    .resetn        (resetn),
    .pll_locked    (pll_locked),
    .div_value     (div_value),
    .div_load      (div_load),
    .clk_out       (clk_out),
    .clk_en        (clk_en),
    .domain_resetn (domain_resetn),
    .seq_done      (seq_done),
    .led           (led)
  );

  always #5 CLK_16mhz = ~CLK_16mhz;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model. m_lock_run = consecutive cycles the sequencer has seen a
  // synchronised lock; domain k is free once that run is long enough. The
  // divider is tracked as absolute toggle times.
  int         m_lock_run;
  logic [7:0] m_hist;
  logic       m_clk;
  logic       m_en;
  int         m_half;
  int         m_next;
  int         m_pend;
  bit         m_pv;
  int         m_bcnt;

  initial begin
    logic lock_pre;
    forever begin
      @(posedge CLK_16mhz);
      cyc++;
      if (!resetn) begin
        m_lock_run = 0;
        m_hist     = '0;
        m_clk      = 1'b0;
        m_en       = 1'b0;
        m_half     = DIVD + 1;
        m_next     = cyc + DIVD + 1;
        m_pend     = 0;
        m_pv       = 1'b0;
        m_bcnt     = 0;
      end else begin
        lock_pre   = m_hist[S-1];
        m_hist     = {m_hist[6:0], pll_locked};
        m_lock_run = lock_pre ? ((m_lock_run < 1000) ? m_lock_run + 1 : 1000) : 0;
        m_en = 1'b0;
        if (cyc == m_next) begin
          if (m_clk) begin
            m_clk = 1'b0;
            if (m_pv) begin
              m_half = m_pend + 1;
              m_pv   = 1'b0;
            end
          end else begin
            m_clk = 1'b1;
            m_en  = 1'b1;
          end
          m_next = cyc + m_half;
        end
        if (div_load) begin
          m_pend = int'(div_value);
          m_pv   = 1'b1;
        end
        m_bcnt++;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    logic [N-1:0] e_dom;
    logic         e_done;
    logic         e_led;
    forever begin
      @(negedge CLK_16mhz);
      if (cyc > 0) begin
        for (int k = 0; k < N; k++) e_dom[k] = (m_lock_run >= 1 + R + k * G);
        e_done = (m_lock_run >= 1 + R + (N - 1) * G);
`ifdef CLK_RST_SEQ_BLINK_EN
        e_led = e_done ? PATTERN[(m_bcnt >> BSHIFT) & 31] : 1'b0;
`else
        e_led = m_clk & e_done;
`endif
        if (!resetn) begin
          check($sformatf("rst dom c%0d", cyc), domain_resetn, 0);
          check($sformatf("rst done c%0d", cyc), seq_done, 0);
          check($sformatf("rst clk c%0d", cyc), clk_out, 0);
          check($sformatf("rst en c%0d", cyc), clk_en, 0);
          check($sformatf("rst led c%0d", cyc), led, 0);
        end else begin
          check($sformatf("dom c%0d", cyc), domain_resetn, e_dom);
          check($sformatf("done c%0d", cyc), seq_done, e_done);
          check($sformatf("clk c%0d", cyc), clk_out, m_clk);
          check($sformatf("en c%0d", cyc), clk_en, m_en);
          check($sformatf("led c%0d", cyc), led, e_led);
        end
      end
    end
  end

  task automatic wait_neg(input int c);
    while (cyc < c) @(negedge CLK_16mhz);
  endtask

  task automatic load_div(input int c, input logic [7:0] v);
    wait_neg(c);
    div_value = v;
    div_load  = 1'b1;
    wait_neg(c + 1);
    div_load  = 1'b0;
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    resetn = 1'b0;
    // Power-up: reset for 5 cycles, lock at cycle 10.
    wait_neg(5);  resetn = 1'b1;
    wait_neg(10); pll_locked = 1'b1;
    wait_neg(20); check("clk@20", clk_out, 0);
    wait_neg(21); check("clk@21", clk_out, 1); check("en@21", clk_en, 1);
    wait_neg(22); check("en@22", clk_en, 0);
    wait_neg(29); check("dom@29", domain_resetn, 3'b000);
    wait_neg(30); check("dom@30", domain_resetn, 3'b001);
    wait_neg(34); check("dom@34", domain_resetn, 3'b011);
    wait_neg(37); check("clk@37", clk_out, 0); check("done@37", seq_done, 0);
    wait_neg(38); check("dom@38", domain_resetn, 3'b111); check("done@38", seq_done, 1);
    wait_neg(53); check("clk@53", clk_out, 1); check("en@53", clk_en, 1);
    // Divisor 3 loaded while clk_out is high (rose at 117).
    load_div(120, 8'd3);
    wait_neg(132); check("clk@132", clk_out, 1);
    wait_neg(133); check("clk@133", clk_out, 0);
    wait_neg(136); check("clk@136", clk_out, 0);
    wait_neg(137); check("clk@137", clk_out, 1); check("en@137", clk_en, 1);
    wait_neg(141); check("clk@141", clk_out, 0);
    // Divisor 0: CLK/2 after the fall at 149.
    load_div(142, 8'd0);
    wait_neg(149); check("clk@149", clk_out, 0);
    wait_neg(150); check("clk@150", clk_out, 1); check("en@150", clk_en, 1);
    wait_neg(151); check("clk@151", clk_out, 0); check("en@151", clk_en, 0);
    // Double load: 5 (on a falling toggle, deferred) then 1; only 1 applies.
    load_div(160, 8'd5);
    load_div(161, 8'd1);
    wait_neg(164); check("clk@164", clk_out, 0);
    wait_neg(165); check("clk@165", clk_out, 1);
    wait_neg(167); check("clk@167", clk_out, 0);
    // Load coincident with the falling toggle at 175 waits for the one at 179.
    load_div(174, 8'd0);
    wait_neg(176); check("clk@176", clk_out, 0);
    wait_neg(177); check("clk@177", clk_out, 1);
    wait_neg(178); check("clk@178", clk_out, 1);
    wait_neg(179); check("clk@179", clk_out, 0);
    wait_neg(180); check("clk@180", clk_out, 1);

    // Lock loss mid-release (times offset by 200).
    wait_neg(200);
    #2 resetn = 1'b0; pll_locked = 1'b0;
    wait_neg(205); resetn = 1'b1;
    wait_neg(210); pll_locked = 1'b1;
    wait_neg(230); check("dom@230", domain_resetn, 3'b001);
    wait_neg(232); pll_locked = 1'b0;
    wait_neg(234); check("dom@234", domain_resetn, 3'b011);
    wait_neg(235); check("dom@235", domain_resetn, 3'b011);
    wait_neg(236); check("dom@236", domain_resetn, 3'b000);
    wait_neg(240); pll_locked = 1'b1;
    wait_neg(259); check("dom@259", domain_resetn, 3'b000);
    wait_neg(260); check("dom@260", domain_resetn, 3'b001);
    wait_neg(268); check("dom@268", domain_resetn, 3'b111); check("done@268", seq_done, 1);

    // Async reset during stretch, with clk_out high.
    wait_neg(300);
    #2 resetn = 1'b0;
    wait_neg(305); resetn = 1'b1;
    wait_neg(322); check("clk@322", clk_out, 1);
    #2 resetn = 1'b0;
    #1;
    check("async clk", clk_out, 0);
    check("async en", clk_en, 0);
    check("async dom", domain_resetn, 3'b000);
    check("async done", seq_done, 0);
    check("async led", led, 0);
    wait_neg(327); resetn = 1'b1;
    wait_neg(343); check("en@343", clk_en, 1);
    wait_neg(346); check("dom@346", domain_resetn, 3'b000);
    wait_neg(347); check("dom@347", domain_resetn, 3'b001);
    wait_neg(354); check("led@354", led, 0); check("done@354", seq_done, 0);
    wait_neg(355); check("done@355", seq_done, 1);
`ifdef CLK_RST_SEQ_BLINK_EN
    wait_neg(360); check("led@360", led, 1);
`else
    wait_neg(360); check("led@360", led, 0);
`endif
    wait_neg(375); check("led@375", led, 1);
    wait_neg(400);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
